// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - source, enable and core handshake bundle for interrupt_controller
interface interrupt_controller_if #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 3
);
   logic [NUM_SRC-1:0] src;
   logic               en_wr;
   logic [NUM_SRC-1:0] en_wdata;
   logic [NUM_SRC-1:0] en;
   logic [NUM_SRC-1:0] pending;
   logic               irq;
   logic [ID_W-1:0]    irq_id;
   logic               irq_ack;
   logic               irq_eoi;
   logic               in_service;

   modport master (
      output src, en_wr, en_wdata, irq_ack, irq_eoi,
      input  en, pending, irq, irq_id, in_service
   );

   modport slave (
      input  src, en_wr, en_wdata, irq_ack, irq_eoi,
      output en, pending, irq, irq_id, in_service
   );
endinterface

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latched, maskable, fixed-priority interrupt controller
module interrupt_controller #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 3
) (
   input logic                  clk,
   input logic                  rst,
   interrupt_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t             state;
   logic [NUM_SRC-1:0] src_prev;
   logic [NUM_SRC-1:0] src_edge;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] id_mask;
   logic [NUM_SRC-1:0] ack_clr;
   logic [ID_W-1:0]    winner;

   always_comb begin
      src_edge = bus.src & ~src_prev;
      eligible = bus.pending & bus.en;
      id_mask  = NUM_SRC'(1) << bus.irq_id;
      ack_clr  = (state == REQ && bus.irq_ack) ? id_mask : '0;
      winner   = '0;
      // Descending scan so the lowest eligible index is the last one written.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = ID_W'(i);
         end
      end
   end

   // A new edge on the source being acknowledged outranks the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_prev    <= '0;
         bus.en      <= '0;
         bus.pending <= '0;
      end else begin
         src_prev    <= bus.src;
         bus.pending <= (bus.pending & ~ack_clr) | src_edge;
         if (bus.en_wr) begin
            bus.en <= bus.en_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         bus.irq        <= 1'b0;
         bus.irq_id     <= '0;
         bus.in_service <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|eligible) begin
                  state      <= REQ;
                  bus.irq    <= 1'b1;
                  bus.irq_id <= winner;
               end
            end
            REQ: begin
               if (bus.irq_ack) begin
                  state          <= SERVICE;
                  bus.irq        <= 1'b0;
                  bus.in_service <= 1'b1;
               end else if ((bus.en & id_mask) == '0) begin
                  state   <= IDLE;
                  bus.irq <= 1'b0;
               end
            end
            SERVICE: begin
               if (bus.irq_eoi) begin
                  state          <= IDLE;
                  bus.in_service <= 1'b0;
               end
            end
            default: begin
               state          <= IDLE;
               bus.irq        <= 1'b0;
               bus.in_service <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - scoreboard bench for interrupt_controller
module tb_interrupt_controller;
   localparam int NUM_SRC = 8;
   localparam int ID_W    = 3;

   logic clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   passed = 0;
   int   exp_q[$];

   always #5 clk = ~clk;

   interrupt_controller_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) bus ();

   interrupt_controller #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs === exp_v) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_en(input logic [NUM_SRC-1:0] m);
      bus.en_wdata = m;
      bus.en_wr    = 1'b1;
      tick();
      bus.en_wr    = 1'b0;
   endtask

   task automatic pulse(input logic [NUM_SRC-1:0] m);
      bus.src = m;
      tick();
      bus.src = '0;
   endtask

   task automatic serve_next();
      int waited;
      int exp_id;
      waited = 0;
      while (!bus.irq && waited < 20) begin
         tick();
         waited++;
      end
      check("irq_wait", 32'(bus.irq), 1);
      if (bus.irq) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 0, 1);
         end else begin
            exp_id = exp_q.pop_front();
            check("sb_irq_id", 32'(bus.irq_id), exp_id);
         end
         bus.irq_ack = 1'b1;
         tick();
         bus.irq_ack = 1'b0;
         check("sb_in_service", 32'(bus.in_service), 1);
         check("sb_irq_low", 32'(bus.irq), 0);
         bus.irq_eoi = 1'b1;
         tick();
         bus.irq_eoi = 1'b0;
         check("sb_eoi", 32'(bus.in_service), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst          = 1'b1;
      bus.src      = '0;
      bus.en_wr    = 1'b0;
      bus.en_wdata = '0;
      bus.irq_ack  = 1'b0;
      bus.irq_eoi  = 1'b0;
      tick();
      tick();
      check("rst_en", 32'(bus.en), 0);
      check("rst_pending", 32'(bus.pending), 0);
      check("rst_irq", 32'(bus.irq), 0);
      check("rst_irq_id", 32'(bus.irq_id), 0);
      check("rst_in_service", 32'(bus.in_service), 0);
      rst = 1'b0;
      tick();

      // single pulse with explicit cycle timing
      write_en(8'h01);
      pulse(8'h01);
      check("sp_pending", 32'(bus.pending), 32'h01);
      check("sp_irq_early", 32'(bus.irq), 0);
      tick();
      check("sp_irq", 32'(bus.irq), 1);
      check("sp_id", 32'(bus.irq_id), 0);
      tick();
      bus.irq_eoi = 1'b1;
      tick();
      bus.irq_eoi = 1'b0;
      check("sp_eoi_in_req", 32'(bus.irq), 1);
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      check("sp_ack_irq", 32'(bus.irq), 0);
      check("sp_ack_svc", 32'(bus.in_service), 1);
      check("sp_ack_pend", 32'(bus.pending), 0);
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      check("sp_ack_in_svc", 32'(bus.in_service), 1);
      bus.irq_eoi = 1'b1;
      tick();
      bus.irq_eoi = 1'b0;
      check("sp_eoi", 32'(bus.in_service), 0);

      // priority: two sources at once, lowest index first
      write_en(8'hFF);
      pulse(8'h24);
      exp_q.push_back(2);
      exp_q.push_back(5);
      serve_next();
      serve_next();
      check("pr_pending", 32'(bus.pending), 0);

      // masked source still latches
      write_en(8'h00);
      pulse(8'h08);
      tick();
      tick();
      check("mk_pending", 32'(bus.pending), 32'h08);
      check("mk_irq", 32'(bus.irq), 0);
      write_en(8'h08);
      check("mk_irq_1", 32'(bus.irq), 0);
      tick();
      check("mk_irq_2", 32'(bus.irq), 1);
      exp_q.push_back(3);
      serve_next();

      // withdrawal, then ack racing with a disabled source
      write_en(8'h02);
      pulse(8'h02);
      tick();
      check("wd_irq", 32'(bus.irq), 1);
      check("wd_id", 32'(bus.irq_id), 1);
      write_en(8'h00);
      tick();
      check("wd_irq_fall", 32'(bus.irq), 0);
      check("wd_pending", 32'(bus.pending), 32'h02);
      write_en(8'h02);
      tick();
      check("wd_reissue", 32'(bus.irq), 1);
      write_en(8'h00);
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      check("wd_ack_wins", 32'(bus.in_service), 1);
      check("wd_ack_pend", 32'(bus.pending), 0);
      bus.irq_eoi = 1'b1;
      tick();
      bus.irq_eoi = 1'b0;

      // new edge in the same cycle as its ack
      write_en(8'h10);
      pulse(8'h10);
      tick();
      check("co_id", 32'(bus.irq_id), 4);
      bus.src     = 8'h10;
      bus.irq_ack = 1'b1;
      tick();
      bus.src     = '0;
      bus.irq_ack = 1'b0;
      check("co_pending", 32'(bus.pending), 32'h10);
      check("co_svc", 32'(bus.in_service), 1);
      check("co_no_irq", 32'(bus.irq), 0);
      bus.irq_eoi = 1'b1;
      tick();
      bus.irq_eoi = 1'b0;
      check("co_idle_gap", 32'(bus.irq), 0);
      tick();
      check("co_reissue", 32'(bus.irq), 1);
      exp_q.push_back(4);
      serve_next();

      // async reset while in service, source held high through it
      write_en(8'hFF);
      pulse(8'h22);
      tick();
      check("rs_id", 32'(bus.irq_id), 1);
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      pulse(8'h02);
      check("rs_pending", 32'(bus.pending), 32'h22);
      check("rs_svc", 32'(bus.in_service), 1);
      bus.src = 8'h08;
      #2;
      rst = 1'b1;
      #1;
      check("rs_irq", 32'(bus.irq), 0);
      check("rs_in_service", 32'(bus.in_service), 0);
      check("rs_pend0", 32'(bus.pending), 0);
      check("rs_en0", 32'(bus.en), 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rs_edge", 32'(bus.pending), 32'h08);
      tick();
      tick();
      check("rs_one_edge", 32'(bus.pending), 32'h08);
      check("rs_masked", 32'(bus.irq), 0);
      write_en(8'h08);
      tick();
      exp_q.push_back(3);
      serve_next();
      tick();
      tick();
      check("rs_level_once", 32'(bus.pending), 0);
      check("rs_level_irq", 32'(bus.irq), 0);
      bus.src = '0;

      check("sb_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
